game_engine_mp: RTL

//  Parametrised N-player game-state engine for the shooting game. Owns player position,

---
 rtl/game_pkg.sv | 25 ++
 rtl/player_unit.sv | 160 ++++++++++++++++
 rtl/game_engine_mp.sv | 119 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings, widths and spawn helpers for the N-player game engine.
package game_pkg;

    typedef enum logic [1:0] {ST_MENU = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;
    typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

    localparam int C_UP    = 0;
    localparam int C_DOWN  = 1;
    localparam int C_LEFT  = 2;
    localparam int C_RIGHT = 3;
    localparam int C_SHOOT = 4;

    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int H_W = 3;

    function automatic logic [X_W-1:0] spawn_x(input int idx, input int n, input int win_w, input int p_w);
        return X_W'(40 + idx * ((win_w - p_w - 80) / (n - 1)));
    endfunction

    function automatic logic [Y_W-1:0] spawn_y(input int idx, input int win_h, input int p_h);
        return (idx % 2 == 0) ? Y_W'(40) : Y_W'(win_h - p_h - 40);
    endfunction

endpackage

// File: rtl/player_unit.sv
// One player: movement with clamping, health, a single bullet and (with SHOT_COOLDOWN_EN)
// a re-fire cooldown counter.
module player_unit
    import game_pkg::*;
#(
    parameter int IDX         = 0,
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_HEALTH  = 3,
    parameter int WIN_W       = 640,
    parameter int WIN_H       = 480,
    parameter int P_W         = 40,
    parameter int P_H         = 40,
    parameter int B_W         = 6,
    parameter int B_H         = 6,
    parameter int P_VEL       = 6,
    parameter int B_VEL       = 15
`ifdef SHOT_COOLDOWN_EN
    ,
    parameter int COOLDOWN    = 8
`endif
) (
    input  logic           game_clk,
    input  logic           reset,
    input  logic           run,
    input  logic           load,
    input  logic           tick,
    input  logic [4:0]     ctrl,
    input  logic [2:0]     hit_cnt,
    input  logic           bullet_hit,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output dir_t           dir,
    output logic [H_W-1:0] health,
    output logic [X_W-1:0] bx,
    output logic [Y_W-1:0] by,
    output logic           bact
);

    typedef logic signed [X_W:0] sx_t;
    typedef logic signed [Y_W:0] sy_t;

    localparam logic [X_W-1:0] SPAWN_X = spawn_x(IDX, NUM_PLAYERS, WIN_W, P_W);
    localparam logic [Y_W-1:0] SPAWN_Y = spawn_y(IDX, WIN_H, P_H);
    localparam sx_t PX_MAX = sx_t'(WIN_W - P_W);
    localparam sy_t PY_MAX = sy_t'(WIN_H - P_H);
    localparam sx_t BX_MAX = sx_t'(WIN_W - B_W);
    localparam sy_t BY_MAX = sy_t'(WIN_H - B_H);

    function automatic logic [X_W-1:0] clamp_x(input sx_t v);
        if (v < 0) return '0;
        if (v > PX_MAX) return PX_MAX[X_W-1:0];
        return v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input sy_t v);
        if (v < 0) return '0;
        if (v > PY_MAX) return PY_MAX[Y_W-1:0];
        return v[Y_W-1:0];
    endfunction

    sx_t  cx, mx, fx, nbx;
    sy_t  cy, my, fy, nby;
    dir_t mdir, bdir;
    logic alive, fire_ok, b_out, cd_zero;

`ifdef SHOT_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN + 1);
    logic [CD_W-1:0] cd;
    assign cd_zero = (cd == '0);
`else
    assign cd_zero = 1'b1;
`endif

    assign alive = (health != '0);

    always_comb begin
        cx   = $signed({1'b0, x});
        cy   = $signed({1'b0, y});
        mx   = cx;
        my   = cy;
        mdir = dir;
        if (ctrl[C_UP]) begin
            my = cy - sy_t'(P_VEL);  mdir = DIR_UP;
        end else if (ctrl[C_DOWN]) begin
            my = cy + sy_t'(P_VEL);  mdir = DIR_DOWN;
        end else if (ctrl[C_LEFT]) begin
            mx = cx - sx_t'(P_VEL);  mdir = DIR_LEFT;
        end else if (ctrl[C_RIGHT]) begin
            mx = cx + sx_t'(P_VEL);  mdir = DIR_RIGHT;
        end
        // Muzzle point sits off-centre on the facing side, based on the pre-move pose.
        case (dir)
            DIR_UP:   begin fx = cx + sx_t'(P_W - 2*B_W); fy = cy - sy_t'(B_H);         end
            DIR_DOWN: begin fx = cx + sx_t'(B_W);         fy = cy + sy_t'(P_H);         end
            DIR_LEFT: begin fx = cx - sx_t'(B_W);         fy = cy + sy_t'(B_H);         end
            default:  begin fx = cx + sx_t'(P_W);         fy = cy + sy_t'(P_H - 2*B_H); end
        endcase
        fire_ok = (fx >= 0) && (fx <= BX_MAX) && (fy >= 0) && (fy <= BY_MAX);
        nbx = $signed({1'b0, bx});
        nby = $signed({1'b0, by});
        case (bdir)
            DIR_UP:   nby = nby - sy_t'(B_VEL);
            DIR_DOWN: nby = nby + sy_t'(B_VEL);
            DIR_LEFT: nbx = nbx - sx_t'(B_VEL);
            default:  nbx = nbx + sx_t'(B_VEL);
        endcase
        b_out = (nbx < 0) || (nbx > BX_MAX) || (nby < 0) || (nby > BY_MAX);
    end

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            x      <= SPAWN_X;
            y      <= SPAWN_Y;
            dir    <= DIR_UP;
            health <= '0;
            bx     <= '0;
            by     <= '0;
            bact   <= 1'b0;
            bdir   <= DIR_UP;
`ifdef SHOT_COOLDOWN_EN
            cd     <= '0;
`endif
        end else if (load) begin
            x      <= SPAWN_X;
            y      <= SPAWN_Y;
            health <= H_W'(MAX_HEALTH);
            bact   <= 1'b0;
`ifdef SHOT_COOLDOWN_EN
            cd     <= '0;
`endif
        end else if (run && tick) begin
            health <= (hit_cnt >= health) ? '0 : health - hit_cnt;
            if (alive) begin
                x   <= clamp_x(mx);
                y   <= clamp_y(my);
                dir <= mdir;
            end
`ifdef SHOT_COOLDOWN_EN
            if (!cd_zero) cd <= cd - 1'b1;
`endif
            if (bact) begin
                if (bullet_hit || b_out) begin
                    bact <= 1'b0;
`ifdef SHOT_COOLDOWN_EN
                    cd   <= CD_W'(COOLDOWN);
`endif
                end else begin
                    bx <= nbx[X_W-1:0];
                    by <= nby[Y_W-1:0];
                end
            end else if (alive && ctrl[C_SHOOT] && cd_zero && fire_ok) begin
                bact <= 1'b1;
                bx   <= fx[X_W-1:0];
                by   <= fy[Y_W-1:0];
                bdir <= dir;
            end
        end
    end

endmodule

// File: rtl/game_engine_mp.sv
// N-player game engine top: MENU/RUNNING/OVER FSM, start edge detect, bullet-vs-player hit
// matrix and winner reduction. Macro SHOT_COOLDOWN_EN enables the per-player re-fire cooldown.
module game_engine_mp
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_HEALTH  = 3,
    parameter int WIN_W       = 640,
    parameter int WIN_H       = 480,
    parameter int P_W         = 40,
    parameter int P_H         = 40,
    parameter int B_W         = 6,
    parameter int B_H         = 6,
    parameter int P_VEL       = 6,
    parameter int B_VEL       = 15
`ifdef SHOT_COOLDOWN_EN
    ,
    parameter int COOLDOWN    = 8
`endif
) (
    input  logic                       game_clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       start,
    input  logic [5*NUM_PLAYERS-1:0]   ctrl,
    output logic [1:0]                 state,
    output logic [2:0]                 winner,
    output logic [X_W*NUM_PLAYERS-1:0] p_x,
    output logic [Y_W*NUM_PLAYERS-1:0] p_y,
    output logic [2*NUM_PLAYERS-1:0]   p_dir,
    output logic [H_W*NUM_PLAYERS-1:0] health,
    output logic [X_W*NUM_PLAYERS-1:0] b_x,
    output logic [Y_W*NUM_PLAYERS-1:0] b_y,
    output logic [NUM_PLAYERS-1:0]     b_act
);

    localparam int N = NUM_PLAYERS;

    state_t         st;
    logic           start_q, run, load;
    logic [X_W-1:0] px [N];
    logic [Y_W-1:0] py [N];
    dir_t           pd [N];
    logic [H_W-1:0] hp [N];
    logic [X_W-1:0] bxs [N];
    logic [Y_W-1:0] bys [N];
    logic [2:0]     hcnt [N];
    logic [N-1:0]   bhit;
    logic [2:0]     alive_cnt, sole;

    assign run   = (st == ST_RUN);
    assign load  = start & ~start_q & ~run;
    assign state = st;

    function automatic logic overlap(input logic [X_W-1:0] bxv, input logic [Y_W-1:0] byv,
                                     input logic [X_W-1:0] pxv, input logic [Y_W-1:0] pyv);
        return (int'(bxv) < int'(pxv) + P_W) && (int'(bxv) + B_W > int'(pxv)) &&
               (int'(byv) < int'(pyv) + P_H) && (int'(byv) + B_H > int'(pyv));
    endfunction

    // Each bullet claims only its lowest-indexed victim; alive count uses post-hit health.
    always_comb begin
        bhit      = '0;
        alive_cnt = '0;
        sole      = '0;
        for (int j = 0; j < N; j++) hcnt[j] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (b_act[i] && !bhit[i] && j != i && hp[j] != '0 &&
                    overlap(bxs[i], bys[i], px[j], py[j])) begin
                    bhit[i] = 1'b1;
                    hcnt[j] = hcnt[j] + 3'd1;
                end
        for (int j = 0; j < N; j++)
            if (hp[j] > hcnt[j]) begin
                alive_cnt = alive_cnt + 3'd1;
                sole      = 3'(j);
            end
    end

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            st      <= ST_MENU;
            winner  <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            if (load) begin
                st <= ST_RUN;
            end else if (run && tick && alive_cnt <= 3'd1) begin
                st     <= ST_OVER;
                winner <= (alive_cnt == '0) ? 3'(N) : sole;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_player
        player_unit #(
            .IDX(i), .NUM_PLAYERS(N), .MAX_HEALTH(MAX_HEALTH),
            .WIN_W(WIN_W), .WIN_H(WIN_H), .P_W(P_W), .P_H(P_H),
            .B_W(B_W), .B_H(B_H), .P_VEL(P_VEL), .B_VEL(B_VEL)
`ifdef SHOT_COOLDOWN_EN
            , .COOLDOWN(COOLDOWN)
`endif
        ) u_player (
            .game_clk(game_clk), .reset(reset), .run(run), .load(load), .tick(tick),
            .ctrl(ctrl[5*i +: 5]), .hit_cnt(hcnt[i]), .bullet_hit(bhit[i]),
            .x(px[i]), .y(py[i]), .dir(pd[i]), .health(hp[i]),
            .bx(bxs[i]), .by(bys[i]), .bact(b_act[i])
        );
        assign p_x[X_W*i +: X_W]    = px[i];
        assign p_y[Y_W*i +: Y_W]    = py[i];
        assign p_dir[2*i +: 2]      = pd[i];
        assign health[H_W*i +: H_W] = hp[i];
        assign b_x[X_W*i +: X_W]    = bxs[i];
        assign b_y[Y_W*i +: Y_W]    = bys[i];
    end

endmodule
